// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: issue / stall / writeback sequencer for the shared multi-cycle MUL/DIV unit.
// Build macro MULTDIV_TIMEOUT_EN adds an abort of WAIT after TIMEOUT cycles (rstatus writeback).
module multdiv_ctrl #(
   parameter int TIMEOUT      = 40,
   parameter int RSTATUS_REG  = 30,
   parameter int MUL_EXC_CODE = 4,
   parameter int DIV_EXC_CODE = 5
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        insn_valid,
   input  logic [4:0]  OP,
   input  logic [4:0]  ALUOP,
   input  logic [4:0]  rd,
   input  logic [31:0] operand_a,
   input  logic [31:0] operand_b,
   input  logic        flush,
   output logic        ctrl_MULT,
   output logic        ctrl_DIV,
   output logic [31:0] md_a,
   output logic [31:0] md_b,
   input  logic        md_resultRDY,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   output logic        stall,
   output logic        wb_valid,
   output logic [4:0]  wb_reg,
   output logic [31:0] wb_data,
   output logic [5:0]  last_latency
);
   localparam logic [4:0] ALU_MUL = 5'b00110;
   localparam logic [4:0] ALU_DIV = 5'b00111;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   if (TIMEOUT < 2 || TIMEOUT > 63) begin : g_bad_timeout
      $error("multdiv_ctrl: TIMEOUT must lie in 2..63");
   end

   state_t      state;
   logic        op_mul;
   logic [4:0]  rd_q;
   logic [5:0]  count;
   logic        mult_q;
   logic        div_q;
   logic        wb_valid_q;
   logic        is_md;

   function automatic logic [5:0] sat_inc(input logic [5:0] v);
      return (v == 6'd63) ? v : v + 6'd1;
   endfunction

   function automatic logic [31:0] exc_code(input logic mul);
      return mul ? 32'(MUL_EXC_CODE) : 32'(DIV_EXC_CODE);
   endfunction

   assign is_md = insn_valid && (OP == 5'b00000) && (ALUOP == ALU_MUL || ALUOP == ALU_DIV);
   assign stall = (state == IDLE && is_md && !flush) || state == ISSUE || state == WAIT;

   // A squash in the same cycle must also suppress an already-registered start or writeback.
   assign ctrl_MULT = mult_q && !flush;
   assign ctrl_DIV  = div_q && !flush;
   assign wb_valid  = wb_valid_q && !flush;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state        <= IDLE;
         op_mul       <= 1'b0;
         rd_q         <= 5'd0;
         count        <= 6'd0;
         mult_q       <= 1'b0;
         div_q        <= 1'b0;
         wb_valid_q   <= 1'b0;
         md_a         <= 32'd0;
         md_b         <= 32'd0;
         wb_reg       <= 5'd0;
         wb_data      <= 32'd0;
         last_latency <= 6'd0;
      end else if (flush) begin
         state      <= IDLE;
         mult_q     <= 1'b0;
         div_q      <= 1'b0;
         wb_valid_q <= 1'b0;
      end else begin
         mult_q     <= 1'b0;
         div_q      <= 1'b0;
         wb_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (is_md) begin
                  md_a   <= operand_a;
                  md_b   <= operand_b;
                  rd_q   <= rd;
                  op_mul <= (ALUOP == ALU_MUL);
                  count  <= 6'd0;
                  mult_q <= (ALUOP == ALU_MUL);
                  div_q  <= (ALUOP == ALU_DIV);
                  state  <= ISSUE;
               end
            end
            ISSUE: state <= WAIT;
            WAIT: begin
               count <= sat_inc(count);
               if (md_resultRDY) begin
                  wb_valid_q   <= 1'b1;
                  wb_reg       <= md_exception ? 5'(RSTATUS_REG) : rd_q;
                  wb_data      <= md_exception ? exc_code(op_mul) : md_result;
                  last_latency <= sat_inc(count);
                  state        <= DONE;
               end
`ifdef MULTDIV_TIMEOUT_EN
               else if (count == 6'(TIMEOUT - 1)) begin
                  wb_valid_q   <= 1'b1;
                  wb_reg       <= 5'(RSTATUS_REG);
                  wb_data      <= exc_code(op_mul);
                  last_latency <= 6'(TIMEOUT);
                  state        <= DONE;
               end
`endif
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Sequencing controller between the decode/execute stage and the shared multi-cycle multiply/divide unit.
- Decodes R-type MUL/DIV (OP=00000, ALUOP=00110 / 00111), latches operands and issues a one-cycle start pulse to the unit.
- Stalls the pipeline until the unit reports ready, then presents a one-cycle writeback, redirecting to $rstatus (r30) on exception.

Parameters:
- TIMEOUT, 40, WAIT cycles before abort; used only with MULTDIV_TIMEOUT_EN; legal 2..63.
- RSTATUS_REG, 30, destination register for exception writeback.
- MUL_EXC_CODE, 4, value written to RSTATUS_REG on multiply exception.
- DIV_EXC_CODE, 5, value written to RSTATUS_REG on divide exception.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- insn_valid  in  1  execute-stage instruction valid.
- OP  in  5  opcode field.
- ALUOP  in  5  ALU op field.
- rd  in  5  destination register.
- operand_a  in  32  rs value.
- operand_b  in  32  rt value.
- flush  in  1  cancel in-flight op (branch/jump squash).
- ctrl_MULT  out  1  one-cycle multiply start.
- ctrl_DIV  out  1  one-cycle divide start.
- md_a  out  32  latched operand A to the unit.
- md_b  out  32  latched operand B to the unit.
- md_resultRDY  in  1  unit result valid.
- md_result  in  32  unit result.
- md_exception  in  1  unit overflow / divide-by-zero.
- stall  out  1  hold PC and earlier pipeline registers.
- wb_valid  out  1  writeback valid, one cycle.
- wb_reg  out  5  writeback register.
- wb_data  out  32  writeback data.
- last_latency  out  6  cycles spent in WAIT by the last completed op.

Behaviour:
- Reset (reset=0 at clock edge): state=IDLE.
  - ctrl_MULT=ctrl_DIV=wb_valid=0.
  - md_a, md_b, wb_reg, wb_data, last_latency, cycle counter = 0.
- is_md = insn_valid & OP==00000 & ALUOP in {00110, 00111}.
- stall is combinational: (state==IDLE & is_md & ~flush) | state==ISSUE | state==WAIT. It is 0 in DONE.
- IDLE:
  - On is_md & ~flush: latch operand_a/b into md_a/b, latch rd and the op type (mul/div), clear counter, go to ISSUE.
  - Any other instruction: no action.
- ISSUE:
  - Exactly one cycle with ctrl_MULT (mul) or ctrl_DIV (div) = 1; both are never 1 together.
  - md_resultRDY is ignored in this state.
  - Go to WAIT.
- WAIT:
  - Counter increments each cycle, saturating at 63.
  - On md_resultRDY: capture md_result/md_exception, set last_latency = counter+1, go to DONE.
- DONE:
  - wb_valid=1 for one cycle.
  - No exception: wb_reg = latched rd, wb_data = captured result.
  - Exception: wb_reg = RSTATUS_REG, wb_data = MUL_EXC_CODE or DIV_EXC_CODE.
  - Decode is ignored in DONE: the MUL/DIV still shown on insn_valid is the one retiring. Go to IDLE.
- Latency: decode to wb_valid = 3 + N cycles, where N = WAIT cycles until ready (minimum N=1).
- flush:
  - In any state, go to IDLE next edge; ctrl_* and wb_valid are 0 that cycle.
  - last_latency is unchanged.
  - flush beats md_resultRDY and beats a new is_md in the same cycle.
- A late md_resultRDY arriving in IDLE is discarded.
- Back-to-back MUL/DIV: the second is accepted on the IDLE cycle after DONE.
- reset takes priority over all other inputs, including mid-WAIT. The unit is expected to be reset by the same signal.
- rd==0 with no exception: wb_valid still pulses with wb_reg=0; the register file discards the write.

Optional Feature:
- Macro: MULTDIV_TIMEOUT_EN.
- Defined:
  - In WAIT, if the counter reaches TIMEOUT-1 without md_resultRDY, go to DONE treating the op as an exception (rstatus writeback).
  - last_latency = TIMEOUT.
  - md_resultRDY on that same cycle wins: normal completion.
- Undefined: WAIT persists indefinitely; no abort logic is synthesised.

Test Plan:
- MUL 7*6, rd=3, ready after 5 WAIT cycles:
  - ctrl_MULT pulses once; stall high 7 cycles.
  - wb_valid, wb_reg=3, wb_data=42; last_latency=5.
- DIV 10/0, unit returns exception:
  - ctrl_DIV pulse; wb_reg=30, wb_data=5.
  - ctrl_MULT never asserted.
- MUL in flight, flush asserted on WAIT cycle 3 with md_resultRDY=1 the same cycle:
  - IDLE next cycle; no wb_valid; stall 0; last_latency unchanged.
- Back-to-back MUL then DIV:
  - Two distinct start pulses and two wb_valid pulses, in order.
  - DIV start pulse comes exactly 2 cycles after the MUL wb_valid.
- reset=0 mid-WAIT:
  - All outputs 0 next edge.
  - An md_resultRDY arriving afterwards causes no writeback.
- With MULTDIV_TIMEOUT_EN and TIMEOUT=40, ready never asserted:
  - wb_valid at WAIT cycle 40, wb_reg=30, wb_data=4, last_latency=40.
  - Without the macro: stall remains high past 100 cycles.
